// File: rtl/fsm_sched_pkg.sv
// Shared types and default constants for the FSM job scheduler.
//   sched_state_e      : scheduler states IDLE, START, WAIT, ACK
//   NUM_REQ_DEF        : default number of requesters
//   TIMEOUT_CYCLES_DEF : default WAIT-state cycle limit (timeout build only)
package fsm_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } sched_state_e;

   localparam int NUM_REQ_DEF        = 4;
   localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/fsm_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter used by the FSM job scheduler.
// The search starts at ptr and walks ptr+1, ptr+2, ... modulo NUM_REQ.
// The first set request bit wins. No state is held here.
// Ports:
//   req         in  NUM_REQ  pending request levels
//   ptr         in  OWNER_W  index that has highest priority
//   enable      in  1        arbitration allowed this cycle
//   grant_idx   out OWNER_W  index of the winning requester
//   grant_valid out 1        a requester won (enable and some req set)
module rr_arbiter
   import fsm_sched_pkg::*;
#(
   parameter int  NUM_REQ = NUM_REQ_DEF,
   localparam int OWNER_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [OWNER_W-1:0] ptr,
   input  logic               enable,
   output logic [OWNER_W-1:0] grant_idx,
   output logic               grant_valid
);

   // The loop runs from the farthest offset down to offset 0.
   // The nearest requester after ptr therefore makes the last assignment and wins.
   always_comb begin
      int sum_v;
      int idx_v;
      sum_v       = 0;
      idx_v       = 0;
      grant_valid = 1'b0;
      grant_idx   = {OWNER_W{1'b0}};
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sum_v = int'(ptr) + i;
         idx_v = (sum_v >= NUM_REQ) ? (sum_v - NUM_REQ) : sum_v;
         if (enable && req[idx_v[OWNER_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = idx_v[OWNER_W-1:0];
         end else begin
            grant_valid = grant_valid;
            grant_idx   = grant_idx;
         end
      end
   end

endmodule

// File: rtl/fsm_job_scheduler.sv
// Shares one FSM engine among NUM_REQ requesters.
// Pending requests are arbitrated round-robin.
// The scheduler issues a one-cycle start to the engine and waits for its done pulse.
// It then returns a one-cycle ack to the requester that owns the job.
// Optional feature macro: FSM_SCHED_TIMEOUT_EN.
//   When defined, a WAIT that lasts TIMEOUT_CYCLES cycles is forced to ACK,
//   and timeout_o pulses together with ack_o.
// Ports:
//   clk       in  1        clock, rising edge
//   rst_n     in  1        asynchronous active-low reset
//   req_i     in  NUM_REQ  level request per client, held until its ack
//   ack_o     out NUM_REQ  one-cycle completion pulse, one-hot or zero
//   busy_o    out 1        high whenever the scheduler is not idle
//   owner_o   out OWNER_W  client being served, valid while busy_o
//   start_o   out 1        one-cycle start pulse to the engine
//   done_i    in  1        one-cycle done pulse from the engine
//   timeout_o out 1        timeout pulse alongside ack_o (tied low without the macro)
module fsm_job_scheduler
   import fsm_sched_pkg::*;
#(
   parameter int  NUM_REQ        = NUM_REQ_DEF,
   parameter int  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   localparam int OWNER_W        = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] ack_o,
   output logic               busy_o,
   output logic [OWNER_W-1:0] owner_o,
   output logic               start_o,
   input  logic               done_i,
   output logic               timeout_o
);

   localparam logic [NUM_REQ-1:0] ACK_LSB = NUM_REQ'(1);

   sched_state_e       state_r;
   sched_state_e       next_state_s;
   logic [OWNER_W-1:0] owner_r;
   logic [OWNER_W-1:0] rr_ptr_r;
   logic [OWNER_W-1:0] ptr_next_s;
   logic [OWNER_W-1:0] grant_idx_s;
   logic               grant_valid_s;
   logic               arb_en_s;
   logic               timeout_hit_s;

   // Arbitration happens only in IDLE, so requests raised while busy simply wait.
   assign arb_en_s = (state_r == IDLE);

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .req         (req_i),
      .ptr         (rr_ptr_r),
      .enable      (arb_en_s),
      .grant_idx   (grant_idx_s),
      .grant_valid (grant_valid_s)
   );

   // The next search starts just past the owner that was served, wrapping at NUM_REQ-1.
   assign ptr_next_s = (owner_r == OWNER_W'(NUM_REQ - 1)) ? {OWNER_W{1'b0}}
                                                          : owner_r + OWNER_W'(1);

`ifdef FSM_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt_r;
   logic             timeout_r;

   // The counter reads TIMEOUT_CYCLES-1 in the last allowed WAIT cycle.
   assign timeout_hit_s = (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

   // WAIT-cycle counter plus the timeout flag that lines up with the ACK cycle.
   // A done pulse in the final cycle takes precedence over the timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_r <= {CNT_W{1'b0}};
         timeout_r  <= 1'b0;
      end else begin
         if (state_r == START) begin
            wait_cnt_r <= {CNT_W{1'b0}};
         end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
         timeout_r <= (state_r == WAIT) && !done_i && timeout_hit_s;
      end
   end
`else
   assign timeout_hit_s = 1'b0;
`endif

   // State register, latched owner and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         owner_r  <= {OWNER_W{1'b0}};
         rr_ptr_r <= {OWNER_W{1'b0}};
      end else begin
         state_r <= next_state_s;
         if ((state_r == IDLE) && grant_valid_s) begin
            owner_r <= grant_idx_s;
         end else begin
            owner_r <= owner_r;
         end
         if (state_r == ACK) begin
            rr_ptr_r <= ptr_next_s;
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
      end
   end

   // Next-state logic. Outside WAIT, done_i has no effect.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_valid_s) begin
               next_state_s = START;
            end else begin
               next_state_s = IDLE;
            end
         end
         START: next_state_s = WAIT;
         WAIT: begin
            if (done_i || timeout_hit_s) begin
               next_state_s = ACK;
            end else begin
               next_state_s = WAIT;
            end
         end
         ACK:     next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Outputs decode only from registered state and owner, so they do not glitch.
   always_comb begin
      start_o = (state_r == START);
      busy_o  = (state_r != IDLE);
      owner_o = owner_r;
      ack_o   = {NUM_REQ{1'b0}};
      if (state_r == ACK) begin
         ack_o = ACK_LSB << owner_r;
      end else begin
         ack_o = {NUM_REQ{1'b0}};
      end
`ifdef FSM_SCHED_TIMEOUT_EN
      timeout_o = timeout_r;
`else
      timeout_o = 1'b0;
`endif
   end

endmodule
